// File: rtl/datapath_gearbox_fifo.sv
// datapath_gearbox_fifo
//   Lane-granular width-converting FIFO. Writes accept IN_LANES lanes per
//   word, reads deliver OUT_LANES lanes per word, and reads are paced by a
//   free-running tick every CLK_DIV cycles. Storage is a ring of DEPTH_LANES
//   lanes; DEPTH_LANES need not be a power of two.
//
//   Ports
//     clk, rst            single clock, synchronous active-high reset
//     wr, data_in         write request and word (MS lane is first in stream)
//     rd                  read request, honoured only when rd_tick is high
//     err_clr             clears the sticky overflow/underflow flags
//     clear               soft clear (active only with DGF_SOFT_CLEAR_EN)
//     data_out            registered read word (MS lane is oldest)
//     rd_valid            one-cycle pulse when data_out was updated
//     rd_tick             pacing tick for consumer alignment
//     data_count          occupancy in lanes
//     full/empty/threshold status derived from data_count
//     overflow/underflow  sticky error flags
//
//   Build option
//     DGF_SOFT_CLEAR_EN   when defined, clear=1 empties the FIFO and clears
//                         the error flags; otherwise clear is ignored.

module datapath_gearbox_fifo #(
    parameter int unsigned LANE_W       = 64,
    parameter int unsigned IN_LANES     = 2,
    parameter int unsigned OUT_LANES    = 3,
    parameter int unsigned DEPTH_LANES  = 48,
    parameter int unsigned CLK_DIV      = 30,
    parameter int unsigned THRESH_LANES = 24
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr,
    input  logic [IN_LANES*LANE_W-1:0]           data_in,
    input  logic                                 rd,
    input  logic                                 err_clr,
    input  logic                                 clear,
    output logic [OUT_LANES*LANE_W-1:0]          data_out,
    output logic                                 rd_valid,
    output logic                                 rd_tick,
    output logic [$clog2(DEPTH_LANES+1)-1:0]     data_count,
    output logic                                 full,
    output logic                                 empty,
    output logic                                 threshold,
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam int unsigned CNT_W  = $clog2(DEPTH_LANES + 1);
    localparam int unsigned PTR_W  = $clog2(DEPTH_LANES);
    localparam int unsigned TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PTR_W-1:0]            wp_q, wp_d;
    logic [PTR_W-1:0]            rp_q, rp_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [TICK_W-1:0]           tick_q, tick_d;
    logic [OUT_LANES*LANE_W-1:0] data_out_q, data_out_d;
    logic                        rd_valid_q, rd_valid_d;
    logic                        overflow_q, overflow_d;
    logic                        underflow_q, underflow_d;

    logic [LANE_W-1:0]           ring_q [DEPTH_LANES];
    logic [PTR_W-1:0]            wr_idx [IN_LANES];
    logic [PTR_W-1:0]            rd_idx [OUT_LANES];

    logic                        wr_en;
    logic                        rd_en;
    logic                        soft_clr;

    // Ring index advance: operands are both below DEPTH_LANES, so a single
    // conditional subtraction always lands back in range.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input int unsigned      k);
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W+1)'(k);
        if (s >= (PTR_W+1)'(DEPTH_LANES)) begin
            s = s - (PTR_W+1)'(DEPTH_LANES);
        end
        return s[PTR_W-1:0];
    endfunction

`ifdef DGF_SOFT_CLEAR_EN
    assign soft_clr = clear;
`else
    logic unused_clear;
    assign unused_clear = clear;
    assign soft_clr     = 1'b0;
`endif

    // Status is combinational from the registered (pre-update) count.
    always_comb begin
        rd_tick   = (tick_q == TICK_W'(CLK_DIV - 1));
        full      = (count_q > CNT_W'(DEPTH_LANES - IN_LANES));
        empty     = (count_q < CNT_W'(OUT_LANES));
        threshold = (count_q >= CNT_W'(THRESH_LANES));
    end

    always_comb begin
        tick_d = rd_tick ? '0 : tick_q + TICK_W'(1);

        // Soft clear drops any same-cycle transfer.
        wr_en = wr & ~full & ~soft_clr;
        rd_en = rd & rd_tick & ~empty & ~soft_clr;

        for (int unsigned i = 0; i < IN_LANES; i++) begin
            wr_idx[i] = ptr_add(wp_q, i);
        end
        for (int unsigned j = 0; j < OUT_LANES; j++) begin
            rd_idx[j] = ptr_add(rp_q, j);
        end

        wp_d       = wr_en ? ptr_add(wp_q, IN_LANES)  : wp_q;
        rp_d       = rd_en ? ptr_add(rp_q, OUT_LANES) : rp_q;

        count_d = count_q;
        if (wr_en) begin
            count_d = count_d + CNT_W'(IN_LANES);
        end
        if (rd_en) begin
            count_d = count_d - CNT_W'(OUT_LANES);
        end

        data_out_d = data_out_q;
        if (rd_en) begin
            for (int unsigned j = 0; j < OUT_LANES; j++) begin
                data_out_d[(OUT_LANES-1-j)*LANE_W +: LANE_W] = ring_q[rd_idx[j]];
            end
        end
        rd_valid_d = rd_en;

        // A new error event in the same cycle as err_clr keeps the flag set.
        overflow_d  = (overflow_q  & ~err_clr) | (wr & full);
        underflow_d = (underflow_q & ~err_clr) | (rd & rd_tick & empty);

        if (soft_clr) begin
            wp_d        = '0;
            rp_d        = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            tick_q      <= '0;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            tick_q      <= tick_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Lane storage carries no reset; the pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            for (int unsigned i = 0; i < IN_LANES; i++) begin
                ring_q[wr_idx[i]] <= data_in[(IN_LANES-1-i)*LANE_W +: LANE_W];
            end
        end
    end

    assign data_out   = data_out_q;
    assign rd_valid   = rd_valid_q;
    assign data_count = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule
